// File: rtl/sm_sat_accum_if.sv
// Purpose: operand/result handshake bundle for the sign-magnitude saturating accumulator.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface sm_sat_accum_if #(
    parameter int W     = 8,
    parameter int GUARD = 1
);
    localparam int OW = W + GUARD;

    // operand side
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a_mag;
    logic          a_sign;
    logic [W-1:0]  b_mag;
    logic          b_sign;
    logic          mode;
    logic          clr;

    // result side
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_mag;
    logic          out_sign;
    logic          out_sat;

    // operand source / result consumer view
    modport master (
        output in_valid, a_mag, a_sign, b_mag, b_sign, mode, clr, out_ready,
        input  in_ready, out_valid, out_mag, out_sign, out_sat
    );

    // accumulator view
    modport slave (
        input  in_valid, a_mag, a_sign, b_mag, b_sign, mode, clr, out_ready,
        output in_ready, out_valid, out_mag, out_sign, out_sat
    );
endinterface

// File: rtl/sm_sat_accum.sv
// Purpose: pipelined sign-magnitude saturating adder (mode 0) / accumulator (mode 1); SM_ACC_STICKY_EN adds sat_sticky.
// Latency: 2 register stages; a beat handshaked in cycle c is presented in cycle c+2; 1 beat/cycle.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result holds the whole pipe frozen.
module sm_sat_accum #(
    parameter int W     = 8,
    parameter int GUARD = 1
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SM_ACC_STICKY_EN
    output logic sat_sticky,
`endif
    sm_sat_accum_if.slave bus
);
    localparam int OW = W + GUARD;
    // Two extra bits: one for sign, one so a+b (or acc+a) can never wrap.
    localparam int SW = OW + 2;

    typedef logic signed [SW-1:0] tc_t;

    localparam tc_t MAX_TC = tc_t'({2'b00, {OW{1'b1}}});
    localparam tc_t MIN_TC = -MAX_TC;

    // Sign-magnitude to two's complement; a negative zero maps onto plain zero.
    function automatic tc_t sm_to_tc(input logic [W-1:0] mag, input logic sgn);
        tc_t m;
        m = tc_t'({{(SW - W){1'b0}}, mag});
        return sgn ? -m : m;
    endfunction

    logic pipe_en;

    // stage 1: operands in two's complement
    logic s1_vld_q,  s1_vld_d;
    tc_t  s1_a_q,    s1_a_d;
    tc_t  s1_b_q,    s1_b_d;
    logic s1_mode_q, s1_mode_d;
    logic s1_clr_q,  s1_clr_d;

    // stage 2: result registers and running accumulator
    logic          out_vld_q,  out_vld_d;
    logic [OW-1:0] out_mag_q,  out_mag_d;
    logic          out_sign_q, out_sign_d;
    logic          out_sat_q,  out_sat_d;
    tc_t           acc_q,      acc_d;

    // stage 2 combinational datapath
    tc_t           base;
    tc_t           addend;
    tc_t           sum;
    tc_t           res_tc;
    logic          res_sat;
    logic [OW-1:0] res_mag;
    logic          res_sign;

    // The whole pipe advances together; a held result blocks everything upstream.
    assign pipe_en      = !out_vld_q || bus.out_ready;
    assign bus.in_ready = pipe_en;

    assign bus.out_valid = out_vld_q;
    assign bus.out_mag   = out_mag_q;
    assign bus.out_sign  = out_sign_q;
    assign bus.out_sat   = out_sat_q;

    // Stage 1 next state: capture converted operands on accept, drop valid on a bubble.
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_mode_d = s1_mode_q;
        s1_clr_d  = s1_clr_q;
        if (pipe_en) begin
            s1_vld_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_a_d    = sm_to_tc(bus.a_mag, bus.a_sign);
                s1_b_d    = sm_to_tc(bus.b_mag, bus.b_sign);
                s1_mode_d = bus.mode;
                s1_clr_d  = bus.clr;
            end
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_mode_q <= 1'b0;
            s1_clr_q  <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_mode_q <= s1_mode_d;
            s1_clr_q  <= s1_clr_d;
        end
    end

    // Add and clamp. acc_q already holds the previous mode-1 beat's result when the
    // next beat reaches this point, so back-to-back accumulation needs no forwarding.
    always_comb begin
        base   = s1_clr_q ? tc_t'(0) : acc_q;
        addend = s1_mode_q ? base : s1_b_q;
        sum    = s1_a_q + addend;
        res_tc  = sum;
        res_sat = 1'b0;
        if (sum > MAX_TC) begin
            res_tc  = MAX_TC;
            res_sat = 1'b1;
        end else if (sum < MIN_TC) begin
            res_tc  = MIN_TC;
            res_sat = 1'b1;
        end
        // |res_tc| <= MAX always fits in OW bits, so the low bits suffice for negation.
        res_sign = res_tc[SW-1];
        res_mag  = res_sign ? (~res_tc[OW-1:0] + OW'(1)) : res_tc[OW-1:0];
    end

    // Stage 2 next state: result registers and accumulator move only on pipe advance.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_mag_d  = out_mag_q;
        out_sign_d = out_sign_q;
        out_sat_d  = out_sat_q;
        acc_d      = acc_q;
        if (pipe_en) begin
            out_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                out_mag_d  = res_mag;
                out_sign_d = res_sign;
                out_sat_d  = res_sat;
                if (s1_mode_q) begin
                    acc_d = res_tc;
                end else if (s1_clr_q) begin
                    acc_d = '0;
                end
            end
        end
    end

    // Stage 2 registers; reset discards any beat in flight and zeroes the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_mag_q  <= '0;
            out_sign_q <= 1'b0;
            out_sat_q  <= 1'b0;
            acc_q      <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_mag_q  <= out_mag_d;
            out_sign_q <= out_sign_d;
            out_sat_q  <= out_sat_d;
            acc_q      <= acc_d;
        end
    end

`ifdef SM_ACC_STICKY_EN
    logic out_clr_q,    out_clr_d;
    logic sat_sticky_q, sat_sticky_d;

    // Track the clr flag of the presented beat and fold saturation into the sticky
    // flag as each beat leaves; a departing clr beat restarts it from its own sat.
    always_comb begin
        out_clr_d    = out_clr_q;
        sat_sticky_d = sat_sticky_q;
        if (pipe_en && s1_vld_q) begin
            out_clr_d = s1_clr_q;
        end
        if (out_vld_q && bus.out_ready) begin
            sat_sticky_d = out_clr_q ? out_sat_q : (sat_sticky_q | out_sat_q);
        end
    end

    // Sticky-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_clr_q    <= 1'b0;
            sat_sticky_q <= 1'b0;
        end else begin
            out_clr_q    <= out_clr_d;
            sat_sticky_q <= sat_sticky_d;
        end
    end

    assign sat_sticky = sat_sticky_q;
`endif

endmodule

// File: tb/tb_sm_sat_accum.sv
// Purpose: self-checking bench for sm_sat_accum (W=8, GUARD=1 main instance plus a GUARD=0 instance).
// Latency: expects results two cycles after the handshake cycle, in order, exactly once.
// Backpressure: exercises a mid-stream out_ready stall and checks in_ready and output hold.
module tb_sm_sat_accum;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sm_sat_accum_if #(.W(8), .GUARD(1)) bus ();
    sm_sat_accum_if #(.W(8), .GUARD(0)) gbus ();

`ifdef SM_ACC_STICKY_EN
    logic sticky_main;
    logic sticky_g0;
`endif

    sm_sat_accum #(.W(8), .GUARD(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef SM_ACC_STICKY_EN
        .sat_sticky (sticky_main),
`endif
        .bus        (bus)
    );

    sm_sat_accum #(.W(8), .GUARD(0)) dut_g0 (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef SM_ACC_STICKY_EN
        .sat_sticky (sticky_g0),
`endif
        .bus        (gbus)
    );

    typedef struct {
        logic       mode;
        logic       clr;
        logic       a_sign;
        logic [7:0] a_mag;
        logic       b_sign;
        logic [7:0] b_mag;
        logic       e_sign;
        logic [8:0] e_mag;
        logic       e_sat;
    } vec_t;

    typedef struct packed {
        logic       sgn;
        logic [8:0] mag;
        logic       sat;
    } res_t;

    res_t exp_q[$];
    int   total  = 0;
    int   bad    = 0;
    int   popped = 0;
    int   popped_before;
    vec_t vecs[18];
    vec_t stall_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Result monitor: every beat leaving the DUT is matched against the head of the queue.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got sign=%0d mag=%0d sat=%0d, expected no beat",
                         bus.out_sign, bus.out_mag, bus.out_sat);
            end else begin
                check($sformatf("result%0d {sign,mag,sat}", popped),
                      {bus.out_sign, bus.out_mag, bus.out_sat}, exp_q.pop_front());
            end
            popped++;
        end
    end

    // Present one beat; push its expected result in the cycle it is handshaked.
    task automatic send(input vec_t v);
        bus.mode     = v.mode;
        bus.clr      = v.clr;
        bus.a_sign   = v.a_sign;
        bus.a_mag    = v.a_mag;
        bus.b_sign   = v.b_sign;
        bus.b_mag    = v.b_mag;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back({v.e_sign, v.e_mag, v.e_sat});
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        total++;
        bad++;
        $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected accept");
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
        check(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // One isolated mode-0 beat through the GUARD=0 instance, checked when it appears.
    task automatic g0_beat(input string name, input logic clr,
                           input logic as, input logic [7:0] a, input logic bs, input logic [7:0] b,
                           input logic es, input logic [7:0] em, input logic esat);
        gbus.mode     = 1'b0;
        gbus.clr      = clr;
        gbus.a_sign   = as;
        gbus.a_mag    = a;
        gbus.b_sign   = bs;
        gbus.b_mag    = b;
        gbus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        gbus.in_valid = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (gbus.out_valid) break;
        end
        check({name, "_vld"}, gbus.out_valid, 1);
        check(name, {gbus.out_sign, gbus.out_mag, gbus.out_sat}, {es, em, esat});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        //          mode clr as  a     bs  b     es  mag  sat
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd5,   1'b0, 8'd0,   1'b0, 9'd5,   1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'd200, 1'b1, 8'd100, 1'b0, 9'd100, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'd0,   1'b1, 8'd0,   1'b0, 9'd0,   1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'd255, 1'b0, 8'd0,   1'b0, 9'd255, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'd255, 1'b0, 8'd0,   1'b0, 9'd510, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'd255, 1'b0, 8'd0,   1'b0, 9'd511, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'd255, 1'b0, 8'd0,   1'b0, 9'd511, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'd255, 1'b0, 8'd0,   1'b0, 9'd256, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'd255, 1'b0, 8'd0,   1'b1, 9'd255, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'd10,  1'b0, 8'd20,  1'b0, 9'd30,  1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 8'd255, 1'b0, 8'd0,   1'b1, 9'd510, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 8'd255, 1'b0, 8'd0,   1'b1, 9'd511, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 8'd255, 1'b0, 8'd255, 1'b0, 9'd510, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 8'd255, 1'b1, 8'd255, 1'b1, 9'd510, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 8'd1,   1'b1, 8'd1,   1'b0, 9'd0,   1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 8'd0,   1'b0, 8'd0,   1'b0, 9'd0,   1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 8'd7,   1'b0, 8'd0,   1'b0, 9'd7,   1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 8'd3,   1'b0, 8'd1,   1'b1, 9'd2,   1'b0};

        bus.in_valid  = 1'b0;
        bus.mode      = 1'b0;
        bus.clr       = 1'b0;
        bus.a_sign    = 1'b0;
        bus.a_mag     = '0;
        bus.b_sign    = 1'b0;
        bus.b_mag     = '0;
        bus.out_ready = 1'b1;
        gbus.in_valid  = 1'b0;
        gbus.mode      = 1'b0;
        gbus.clr       = 1'b0;
        gbus.a_sign    = 1'b0;
        gbus.a_mag     = '0;
        gbus.b_sign    = 1'b0;
        gbus.b_mag     = '0;
        gbus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset with two accumulate beats in flight: both are discarded, acc returns to 0.
        send('{1'b1, 1'b0, 1'b0, 8'd100, 1'b0, 8'd0, 1'b0, 9'd100, 1'b0});
        send('{1'b1, 1'b0, 1'b0, 8'd100, 1'b0, 8'd0, 1'b0, 9'd200, 1'b0});
        check("inflight_out_valid", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_mag",   bus.out_mag,   0);
        check("rst_out_sign",  bus.out_sign,  0);
        check("rst_out_sat",   bus.out_sat,   0);
        check("rst_in_ready",  bus.in_ready,  1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back table stream, accumulator chaining included.
        for (int i = 0; i < 18; i++) send(vecs[i]);
        drain("table_drain");

        // Latency: handshake in cycle c, out_valid first seen in cycle c+2.
        send('{1'b0, 1'b0, 1'b0, 8'd200, 1'b1, 8'd100, 1'b0, 9'd100, 1'b0});
        @(negedge clk);
        check("lat_c1_out_valid", bus.out_valid, 0);
        @(negedge clk);
        check("lat_c2_out_valid", bus.out_valid, 1);
        drain("lat_drain");

        // Six-beat stream with out_ready low for four cycles mid-stream.
        popped_before = popped;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    stall_v = '{1'b0, 1'b0, 1'b0, 8'(i * 10 + 1), i[0], 8'd2,
                                1'b0, (i[0] ? 9'(i * 10 - 1) : 9'(i * 10 + 3)), 1'b0};
                    send(stall_v);
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check($sformatf("stall%0d_in_ready", k),  bus.in_ready,  0);
                    check($sformatf("stall%0d_out_valid", k), bus.out_valid, 1);
                    check($sformatf("stall%0d_hold", k),
                          {bus.out_sign, bus.out_mag, bus.out_sat}, {1'b0, 9'd3, 1'b0});
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain("stall_drain");
        check("stall_beat_count", popped - popped_before, 6);

        // GUARD=0: OW=8, MAX=255.
        g0_beat("g0_pos_sat", 1'b0, 1'b0, 8'd255, 1'b0, 8'd255, 1'b0, 8'd255, 1'b1);
`ifdef SM_ACC_STICKY_EN
        check("sticky_after_sat", sticky_g0, 1);
`endif
        g0_beat("g0_small", 1'b0, 1'b0, 8'd1, 1'b0, 8'd1, 1'b0, 8'd2, 1'b0);
`ifdef SM_ACC_STICKY_EN
        check("sticky_holds", sticky_g0, 1);
`endif
        g0_beat("g0_clr", 1'b1, 1'b0, 8'd1, 1'b0, 8'd1, 1'b0, 8'd2, 1'b0);
`ifdef SM_ACC_STICKY_EN
        check("sticky_cleared", sticky_g0, 0);
`endif
        g0_beat("g0_neg_sat", 1'b0, 1'b1, 8'd255, 1'b1, 8'd255, 1'b1, 8'd255, 1'b1);
        g0_beat("g0_clr_sat", 1'b1, 1'b0, 8'd255, 1'b0, 8'd255, 1'b0, 8'd255, 1'b1);
`ifdef SM_ACC_STICKY_EN
        check("sticky_clr_sat", sticky_g0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
